// File: rtl/hdlc_framer.sv
// HDLC transmit framer: opening flag, bit-stuffed LSB-first payload, then closing flag or abort on underrun.
// State and bit counter always describe the bit currently on serOut, so status pulses align with that bit.
module hdlc_framer #(
  parameter logic [7:0] FLAG      = 8'h7E,
  parameter logic [7:0] ABORT_SEQ = 8'hFE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       serOut,
  output logic       busy,
  output logic       frame_done,
  output logic       abort
);

  typedef enum logic [2:0] {IDLE, OPEN, DATA, STUFF, CLOSE, ABORT} state_t;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] ones_cnt, ones_cnt_nxt;
  logic [7:0] shifter, shifter_nxt;
  logic       cur_last, cur_last_nxt;
  logic       hold_full, hold_full_nxt;
  logic [7:0] hold_dat, hold_dat_nxt;
  logic       hold_last, hold_last_nxt;
  logic       last_acc, last_acc_nxt;
  logic       ser_nxt;
  logic       emit_data;
  logic       boundary;

  assign din_ready  = !hold_full && !last_acc &&
                      (state == IDLE || state == OPEN || state == DATA || state == STUFF);
  assign busy       = (state != IDLE);
  assign frame_done = (state == CLOSE) && (bit_cnt == 3'd7);
  assign abort      = (state == ABORT) && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      ones_cnt  <= 3'd0;
      shifter   <= 8'd0;
      cur_last  <= 1'b0;
      hold_full <= 1'b0;
      hold_dat  <= 8'd0;
      hold_last <= 1'b0;
      last_acc  <= 1'b0;
      serOut    <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ones_cnt  <= ones_cnt_nxt;
      shifter   <= shifter_nxt;
      cur_last  <= cur_last_nxt;
      hold_full <= hold_full_nxt;
      hold_dat  <= hold_dat_nxt;
      hold_last <= hold_last_nxt;
      last_acc  <= last_acc_nxt;
      serOut    <= ser_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    ones_cnt_nxt  = ones_cnt;
    shifter_nxt   = shifter;
    cur_last_nxt  = cur_last;
    hold_full_nxt = hold_full;
    hold_dat_nxt  = hold_dat;
    hold_last_nxt = hold_last;
    last_acc_nxt  = last_acc;
    ser_nxt       = 1'b1;
    emit_data     = 1'b0;
    boundary      = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) begin
          state_nxt   = OPEN;
          bit_cnt_nxt = 3'd0;
          ser_nxt     = FLAG[0];
        end
      end
      OPEN: begin
        if (bit_cnt == 3'd7) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
          emit_data   = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          ser_nxt     = FLAG[bit_cnt_nxt];
          // Hold moves to the shifter together with the last flag bit.
          if (bit_cnt == 3'd6) begin
            shifter_nxt   = hold_dat;
            cur_last_nxt  = hold_last;
            hold_full_nxt = 1'b0;
            ones_cnt_nxt  = 3'd0;
          end
        end
      end
      DATA: begin
        if (ones_cnt == 3'd5) begin
          state_nxt    = STUFF;
          ser_nxt      = 1'b0;
          ones_cnt_nxt = 3'd0;
        end else if (bit_cnt != 3'd7) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          emit_data   = 1'b1;
        end else begin
          boundary = 1'b1;
        end
      end
      STUFF: begin
        if (bit_cnt != 3'd7) begin
          state_nxt   = DATA;
          bit_cnt_nxt = bit_cnt + 3'd1;
          emit_data   = 1'b1;
        end else begin
          boundary = 1'b1;
        end
      end
      CLOSE, ABORT: begin
        if (bit_cnt == 3'd7) begin
          state_nxt    = IDLE;
          bit_cnt_nxt  = 3'd0;
          last_acc_nxt = 1'b0;
          if (state == ABORT) hold_full_nxt = 1'b0;
        end else begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          ser_nxt     = (state == CLOSE) ? FLAG[bit_cnt_nxt] : ABORT_SEQ[bit_cnt_nxt];
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (boundary) begin
      bit_cnt_nxt = 3'd0;
      if (cur_last) begin
        state_nxt = CLOSE;
        ser_nxt   = FLAG[0];
      end else if (hold_full) begin
        state_nxt     = DATA;
        shifter_nxt   = hold_dat;
        cur_last_nxt  = hold_last;
        hold_full_nxt = 1'b0;
        emit_data     = 1'b1;
      end else begin
        state_nxt = ABORT;
        ser_nxt   = ABORT_SEQ[0];
      end
    end

    // Ones run is carried across byte boundaries; only payload bits touch it.
    if (emit_data) begin
      ser_nxt      = shifter_nxt[0];
      ones_cnt_nxt = shifter_nxt[0] ? ones_cnt + 3'd1 : 3'd0;
      shifter_nxt  = {1'b0, shifter_nxt[7:1]};
    end

    if (din_valid && din_ready) begin
      hold_full_nxt = 1'b1;
      hold_dat_nxt  = din;
      hold_last_nxt = din_last;
      if (din_last) last_acc_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_hdlc_framer.sv
// Bench for hdlc_framer: a bitstream-level model (flag, stuffed payload, trailer) drives a per-cycle
// expectation queue that one negedge process checks against serOut/busy/frame_done/abort.
module tb_hdlc_framer;

  typedef logic [7:0] bq_t[$];

  localparam logic [7:0] FLAG_V  = 8'h7E;
  localparam logic [7:0] ABORT_V = 8'hFE;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;
  logic       serOut;
  logic       busy;
  logic       frame_done;
  logic       abort;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  hdlc_framer dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .serOut(serOut), .busy(busy), .frame_done(frame_done), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle: {serOut, busy, frame_done, abort}; an empty queue means the line must be idle.
  always @(negedge clk) begin
    logic [3:0] a;
    logic [3:0] e;
    a = {serOut, busy, frame_done, abort};
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1000;
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL line_cycle t=%0t ser/busy/done/abort got %b expected %b", $time, a, e);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, act, want);
    end
  endtask

  // Line bits in time order: flag, payload LSB-first with a 0 after every five 1s, then flag or abort.
  function automatic void build(input bq_t bytes, input bit ab, output logic [127:0] bits, output int n);
    int ones;
    logic b;
    bits = '0;
    n = 0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin bits[n] = FLAG_V[i]; n++; end
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        b = bytes[k][i];
        bits[n] = b; n++;
        ones = b ? ones + 1 : 0;
        if (ones == 5) begin bits[n] = 1'b0; n++; ones = 0; end
      end
    end
    for (int i = 0; i < 8; i++) begin
      bits[n] = ab ? ABORT_V[i] : FLAG_V[i]; n++;
    end
  endfunction

  task automatic pin(input string name, input bq_t bytes, input bit ab,
                     input logic [63:0] lit, input int len);
    logic [127:0] bits;
    logic [63:0]  v;
    int n;
    build(bytes, ab, bits, n);
    v = '0;
    for (int i = 0; i < n && i < 64; i++) v = {v[62:0], bits[i]};
    chk({name, "_len"}, 64'(n), 64'(len));
    chk({name, "_bits"}, v, lit);
  endtask

  // One idle cycle (hold full, FSM still IDLE) precedes the opening flag.
  task automatic enqueue(input logic [127:0] bits, input int n, input bit ab, input int lim);
    exp_q.push_back(4'b1000);
    for (int i = 0; i < n && i < lim; i++)
      exp_q.push_back({bits[i], 1'b1, (i == n-1) && !ab, (i == n-1) && ab});
  endtask

  task automatic put_byte(input logic [7:0] b, input logic last);
    int w;
    w = 0;
    @(negedge clk); #1;
    din = b; din_last = last; din_valid = 1'b1;
    while (!din_ready && w < 300) begin @(negedge clk); #1; w++; end
    if (!din_ready) begin
      n_chk++; n_fail++;
      $display("FAIL din_ready_timeout got 0 expected 1 within 300 cycles");
    end
    @(posedge clk);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin @(negedge clk); #1; w++; end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic send_frame(input string name, input bq_t bytes, input bit ab);
    logic [127:0] bits;
    int n;
    build(bytes, ab, bits, n);
    foreach (bytes[k]) begin
      put_byte(bytes[k], !ab && (k == bytes.size() - 1));
      if (k == 0) enqueue(bits, n, ab, 1000);
    end
    #1;
    din_valid = 1'b0;
    chk({name, "_ready_after_final"}, 64'(din_ready), 64'd0);
    drain(name);
  endtask

  initial begin
    bq_t q;
    logic [127:0] bits;
    int n;

    rst = 1'b1; din = 8'h00; din_valid = 1'b0; din_last = 1'b0;
    #1;
    chk("reset_ser", 64'(serOut), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(din_ready), 64'd1);
    chk("reset_pulses", 64'({frame_done, abort}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    q.delete(); q.push_back(8'h00);
    pin("pin_00", q, 1'b0, 64'b011111100000000001111110, 24);
    send_frame("frame_00", q, 1'b0);

    q.delete(); q.push_back(8'hFF);
    pin("pin_ff", q, 1'b0, 64'b0111111011111011101111110, 25);
    send_frame("frame_ff", q, 1'b0);

    q.delete(); q.push_back(8'hF8); q.push_back(8'h07);
    pin("pin_f8_07", q, 1'b0, 64'b011111100001111101110000001111110, 33);
    send_frame("frame_f8_07", q, 1'b0);

    q.delete(); q.push_back(8'hAA);
    pin("pin_abort", q, 1'b1, 64'b011111100101010101111111, 24);
    send_frame("frame_abort", q, 1'b1);

    // Reset lands while the third payload bit is on the line.
    q.delete(); q.push_back(8'h3C);
    build(q, 1'b0, bits, n);
    put_byte(8'h3C, 1'b1);
    enqueue(bits, n, 1'b0, 11);
    #1 din_valid = 1'b0;
    drain("pre_reset");
    rst = 1'b1;
    #1;
    chk("midframe_rst_ser", 64'(serOut), 64'd1);
    chk("midframe_rst_busy", 64'(busy), 64'd0);
    chk("midframe_rst_ready", 64'(din_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    q.delete(); q.push_back(8'h81);
    send_frame("after_reset", q, 1'b0);

    for (int f = 0; f < 12; f++) begin
      q.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        case ($urandom_range(0, 3))
          0: q.push_back(8'hFF);
          1: q.push_back(8'h7E);
          default: q.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      send_frame($sformatf("rand_%0d", f), q, 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
